// File: rtl/alu_seq_if.sv
// alu_seq_if: opcode/operand issue, start/busy/done handshake and status for alu_seq.
// Y lives outside the bundle as a plain tri-state port so it can join the shared CPU bus directly.
interface alu_seq_if #(parameter int WIDTH = 8);
  logic start;
  logic [3:0] operation;
  logic [WIDTH-1:0] A, B;
  logic OE, busy, done, err;
  logic [3:0] flags;
  modport master(output start, operation, A, B, OE, input busy, done, flags, err);
  modport slave(input start, operation, A, B, OE, output busy, done, flags, err);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with Z/N/C/V flags, start/done handshake, bit-serial shifts and shift-add multiply.
module alu_seq #(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic rst_n,
  alu_seq_if.slave bus,
  output tri [WIDTH-1:0] Y
);
  localparam int SHW = $clog2(WIDTH) + 1;
  localparam logic [SHW-1:0] WN = SHW'(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] result, a_q, hi, lo, hi_n, lo_n, r1;
  logic [WIDTH:0] sum, dif, ms;
  logic [3:0] op, op_q, flags_q, f1, fr;
  logic [SHW-1:0] cnt, bn, n;
  logic sc, sc_n, done_q, err_q, is_sh, is_sub, multi, c1, v1;
  // Issue-cycle datapath: everything that can finish on the start edge
  always_comb begin
    op = bus.operation;
    bn = bus.B[SHW-1:0];
    n = bn > WN ? WN : bn;
    sum = {1'b0, bus.A} + {1'b0, bus.B};
    dif = {1'b0, bus.A} - {1'b0, bus.B};
    is_sh = op == 4'd5 || op == 4'd6 || op == 4'd9;
    is_sub = op == 4'd1 || op == 4'd10;
    multi = op == 4'd8 || (is_sh && n != '0);
    r1 = op == 4'd0 ? sum[WIDTH-1:0] :
         is_sub     ? dif[WIDTH-1:0] :
         op == 4'd2 ? bus.A & bus.B :
         op == 4'd3 ? bus.A | bus.B :
         op == 4'd4 ? bus.A ^ bus.B :
         op == 4'd7 ? ~bus.A :
         is_sh      ? bus.A : '0;
    c1 = op == 4'd0 ? sum[WIDTH] : is_sub ? dif[WIDTH] : 1'b0;
    v1 = op == 4'd0 ? (bus.A[WIDTH-1] == bus.B[WIDTH-1] && sum[WIDTH-1] != bus.A[WIDTH-1]) :
         is_sub     ? (bus.A[WIDTH-1] != bus.B[WIDTH-1] && dif[WIDTH-1] != bus.A[WIDTH-1]) : 1'b0;
    f1 = {r1 == '0, r1[WIDTH-1], c1, v1};
  end
  // One iteration per RUN cycle; MUL shifts the partial product {hi,lo} right, consuming B from lo
  always_comb begin
    ms = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
    hi_n = op_q == 4'd8 ? ms[WIDTH:1] : hi;
    lo_n = op_q == 4'd8 ? {ms[0], lo[WIDTH-1:1]} :
           op_q == 4'd5 ? lo << 1 :
           op_q == 4'd6 ? lo >> 1 : {lo[WIDTH-1], lo[WIDTH-1:1]};
    sc_n = op_q == 4'd5 ? lo[WIDTH-1] : lo[0];
    fr = {lo_n == '0, lo_n[WIDTH-1], op_q == 4'd8 ? |hi_n : sc_n, 1'b0};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (bus.start && multi ? RUN : IDLE) : (cnt == 1 ? IDLE : RUN);
  always_comb begin
    bus.busy = state == RUN;
    bus.done = done_q;
    bus.flags = flags_q;
    bus.err = err_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {result, a_q, hi, lo, op_q, flags_q, cnt} <= '0;
      {sc, done_q, err_q} <= '0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          op_q <= op;
          a_q <= bus.A;
          hi <= '0;
          lo <= op == 4'd8 ? bus.B : bus.A;
          sc <= 1'b0;
          cnt <= op == 4'd8 ? WN : n;
          if (!multi) begin
            if (op != 4'd10) result <= r1;
            flags_q <= f1;
            err_q <= op > 4'd10;
            done_q <= 1'b1;
          end
        end
      end else begin
        hi <= hi_n;
        lo <= lo_n;
        sc <= sc_n;
        cnt <= cnt - 1'b1;
        if (cnt == 1) begin
          result <= lo_n;
          flags_q <= fr;
          err_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  assign Y = bus.OE ? result : 'z;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: alu_seq (WIDTH=8) against an arithmetic reference model, plus directed literal cases.
module tb_alu_seq;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  alu_seq_if #(.WIDTH(8)) bus();
  wire [7:0] y;
  alu_seq #(.WIDTH(8)) dut(.clk(clk), .rst_n(rst_n), .bus(bus), .Y(y));
  int tests = 0, fails = 0;
  typedef struct { logic [7:0] r; logic [3:0] f; logic e; logic keep; int lat; } exp_t;
  function automatic exp_t model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    exp_t x;
    int sa, sb, s, n, p;
    logic c, v;
    sa = a >= 8'd128 ? int'(a) - 256 : int'(a);
    sb = b >= 8'd128 ? int'(b) - 256 : int'(b);
    n = int'(b) % 16;
    if (n > 8) n = 8;
    x.r = 8'h00; x.e = 1'b0; x.keep = 1'b0; x.lat = 1; c = 1'b0; v = 1'b0;
    case (o)
      4'd0: begin s = int'(a) + int'(b); x.r = 8'(s); c = s > 255; v = (sa + sb > 127) || (sa + sb < -128); end
      4'd1, 4'd10: begin
        x.r = 8'(int'(a) - int'(b)); c = a < b; v = (sa - sb > 127) || (sa - sb < -128); x.keep = o == 4'd10;
      end
      4'd2: x.r = a & b;
      4'd3: x.r = a | b;
      4'd4: x.r = a ^ b;
      4'd7: x.r = ~a;
      4'd5: begin x.r = 8'(int'(a) << n); c = n != 0 && ((int'(a) >> (8 - n)) & 1) != 0; x.lat = n + 1; end
      4'd6: begin x.r = 8'(int'(a) >> n); c = n != 0 && ((int'(a) >> (n - 1)) & 1) != 0; x.lat = n + 1; end
      4'd9: begin x.r = 8'(sa >>> n); c = n != 0 && ((sa >>> (n - 1)) & 1) != 0; x.lat = n + 1; end
      4'd8: begin p = int'(a) * int'(b); x.r = 8'(p); c = p > 255; x.lat = 9; end
      default: x.e = 1'b1;
    endcase
    x.f = {x.r == 8'h00, x.r[7], c, v};
    return x;
  endfunction
  logic [7:0] m_res = 8'h00;
  logic [3:0] m_fl = 4'h0;
  logic m_err = 1'b0, m_done = 1'b0;
  int m_left = 0;
  exp_t pend;
  always @(posedge clk or negedge rst_n) begin : mdl
    exp_t x;
    if (!rst_n) begin
      m_res <= 8'h00; m_fl <= 4'h0; m_err <= 1'b0; m_done <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin m_res <= pend.r; m_fl <= pend.f; m_err <= 1'b0; m_done <= 1'b1; end
      end else if (bus.start) begin
        x = model(bus.operation, bus.A, bus.B);
        if (x.lat == 1) begin
          if (!x.keep) m_res <= x.r;
          m_fl <= x.f; m_err <= x.e; m_done <= 1'b1;
        end else begin
          m_left <= x.lat - 1; pend <= x;
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("done", 32'(bus.done), 32'(m_done));
    chk("busy", 32'(bus.busy), 32'(m_left > 0));
    chk("flags", 32'(bus.flags), 32'(m_fl));
    chk("err", 32'(bus.err), 32'(m_err));
    if (bus.OE) chk("Y", 32'(y), 32'(m_res));
  end
  task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input bit mid, output int cyc);
    @(negedge clk);
    bus.start = 1'b1; bus.operation = o; bus.A = a; bus.B = b;
    cyc = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0; bus.A = 8'($urandom); bus.B = 8'($urandom);
      cyc++;
      if (mid && cyc == 3) begin bus.start = 1'b1; bus.operation = 4'd0; end
    end while (!bus.done && cyc < 40);
  endtask
  task automatic expect_op(input string nm, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                           input int lat, input logic [7:0] yv, input logic [3:0] fv, input logic ev);
    int cyc;
    issue(o, a, b, 1'b0, cyc);
    chk({nm, "_lat"}, 32'(cyc), 32'(lat));
    chk({nm, "_Y"}, 32'(y), 32'(yv));
    chk({nm, "_flags"}, 32'(bus.flags), 32'(fv));
    chk({nm, "_err"}, 32'(bus.err), 32'(ev));
  endtask
  initial begin
    int cyc, dones;
    bus.start = 1'b0; bus.operation = 4'd0; bus.A = 8'h00; bus.B = 8'h00; bus.OE = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_Y", 32'(y), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_flags", 32'(bus.flags), 32'h0);
    #2 rst_n = 1'b1;
    expect_op("add", 4'd0, 8'h7F, 8'h01, 1, 8'h80, 4'b0101, 1'b0);
    expect_op("sub", 4'd1, 8'h05, 8'h07, 1, 8'hFE, 4'b0110, 1'b0);
    expect_op("cmp", 4'd10, 8'h33, 8'h33, 1, 8'hFE, 4'b1000, 1'b0);
    expect_op("shl", 4'd5, 8'h81, 8'h03, 4, 8'h08, 4'b0000, 1'b0);
    expect_op("asr", 4'd9, 8'h90, 8'h09, 9, 8'hFF, 4'b0110, 1'b0);
    expect_op("shr0", 4'd6, 8'hA5, 8'h00, 1, 8'hA5, 4'b0100, 1'b0);
    expect_op("shl8", 4'd5, 8'h01, 8'h08, 9, 8'h00, 4'b1010, 1'b0);
    issue(4'd8, 8'h10, 8'h11, 1'b1, cyc);
    chk("mul_lat", 32'(cyc), 32'd9);
    chk("mul_Y", 32'(y), 32'h10);
    chk("mul_flags", 32'(bus.flags), 32'b0010);
    expect_op("undef", 4'hE, 8'h12, 8'h34, 1, 8'h00, 4'b1000, 1'b1);
    expect_op("and", 4'd2, 8'hF0, 8'h3C, 1, 8'h30, 4'b0000, 1'b0);
    bus.OE = 1'b0;
    issue(4'd4, 8'h80, 8'h01, 1'b0, cyc);
    chk("oe0_lat", 32'(cyc), 32'd1);
    chk("oe0_flags", 32'(bus.flags), 32'b0100);
    @(negedge clk);
    bus.OE = 1'b1;
    @(negedge clk);
    chk("oe1_Y", 32'(y), 32'h81);
    @(negedge clk);
    bus.start = 1'b1; bus.operation = 4'd8; bus.A = 8'h37; bus.B = 8'hC5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_Y", 32'(y), 32'h0);
    chk("abort_flags", 32'(bus.flags), 32'h0);
    #2 rst_n = 1'b1;
    dones = 0;
    repeat (12) begin @(negedge clk); if (bus.done) dones++; end
    chk("abort_nodone", 32'(dones), 32'h0);
    expect_op("add2", 4'd0, 8'h22, 8'h11, 1, 8'h33, 4'b0000, 1'b0);
    dones = 0;
    repeat (3000) begin
      @(negedge clk);
      if (bus.done) dones++;
      bus.start = ($urandom % 3) == 0;
      bus.operation = 4'($urandom);
      bus.A = 8'($urandom);
      bus.B = ($urandom % 2) != 0 ? 8'($urandom % 10) : 8'($urandom);
      bus.OE = ($urandom % 4) != 0;
    end
    bus.start = 1'b0;
    chk("rand_progress", 32'(dones > 200), 32'h1);
    repeat (12) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
